// File: rtl/model_state_top_sequencer.sv
// ============================================================================
// Module   : model_state_top_sequencer
// Summary  : Runs a discrete state-space model for K steps on one shared
//            signed fixed-point MAC and streams y(k) one element at a time.
//            Optional macro: MODEL_STATE_SATURATION_EN, which clamps results.
// Revision : 1.0
// ============================================================================
`default_nettype none

module model_state_top_sequencer #(
    parameter int DATA_SIZE     = 64,
    parameter int FRACTION_SIZE = 16,
    parameter int INDEX_SIZE    = 8,
    parameter int N             = 4,
    parameter int X             = 4,
    parameter int Y             = 4
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  START,
    input  logic [INDEX_SIZE-1:0] K_IN,
    input  logic                  WR_ENABLE,
    input  logic [2:0]            WR_SELECT,
    input  logic [INDEX_SIZE-1:0] WR_ROW,
    input  logic [INDEX_SIZE-1:0] WR_COL,
    input  logic [DATA_SIZE-1:0]  WR_DATA,
    output logic                  Y_OUT_ENABLE,
    output logic [INDEX_SIZE-1:0] Y_OUT_INDEX,
    output logic [INDEX_SIZE-1:0] Y_OUT_STEP,
    output logic [DATA_SIZE-1:0]  Y_OUT,
    output logic                  BUSY,
    output logic                  READY
);

    localparam int c_ACC_W = 2 * DATA_SIZE + INDEX_SIZE;
    localparam int c_NI    = (N > 1) ? $clog2(N) : 1;
    localparam int c_XI    = (X > 1) ? $clog2(X) : 1;
    localparam int c_YI    = (Y > 1) ? $clog2(Y) : 1;

    localparam logic [INDEX_SIZE:0] c_N       = (INDEX_SIZE+1)'(N);
    localparam logic [INDEX_SIZE:0] c_X       = (INDEX_SIZE+1)'(X);
    localparam logic [INDEX_SIZE:0] c_Y       = (INDEX_SIZE+1)'(Y);
    localparam logic [INDEX_SIZE:0] c_N_LAST  = (INDEX_SIZE+1)'(N - 1);
    localparam logic [INDEX_SIZE:0] c_Y_LAST  = (INDEX_SIZE+1)'(Y - 1);
    localparam logic [INDEX_SIZE:0] c_NX_LAST = (INDEX_SIZE+1)'(N + X - 1);

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_OUT_ROW  = 3'd1,
        S_OUT_EMIT = 3'd2,
        S_ST_ROW   = 3'd3,
        S_ST_EMIT  = 3'd4,
        S_COMMIT   = 3'd5,
        S_DONE     = 3'd6
    } state_t;

    state_t                       r_state;
    logic [INDEX_SIZE-1:0]        r_row;
    logic [INDEX_SIZE:0]          r_col;
    logic [INDEX_SIZE-1:0]        r_k;
    logic [INDEX_SIZE-1:0]        r_k_max;
    logic signed [c_ACC_W-1:0]    r_acc;

    logic signed [DATA_SIZE-1:0]  r_a  [N][N];
    logic signed [DATA_SIZE-1:0]  r_b  [N][X];
    logic signed [DATA_SIZE-1:0]  r_c  [Y][N];
    logic signed [DATA_SIZE-1:0]  r_d  [Y][X];
    logic signed [DATA_SIZE-1:0]  r_x  [N];
    logic signed [DATA_SIZE-1:0]  r_xn [N];
    logic signed [DATA_SIZE-1:0]  r_u  [X];

    logic                         r_y_en;
    logic [INDEX_SIZE-1:0]        r_y_idx;
    logic [INDEX_SIZE-1:0]        r_y_step;
    logic [DATA_SIZE-1:0]         r_y;
    logic                         r_busy;
    logic                         r_ready;

    logic                         w_st;
    logic [c_NI-1:0]              w_jn;
    logic [c_XI-1:0]              w_ju;
    logic [c_NI-1:0]              w_rn;
    logic [c_YI-1:0]              w_ry;
    logic signed [DATA_SIZE-1:0]  w_coef;
    logic signed [DATA_SIZE-1:0]  w_vec;
    logic signed [2*DATA_SIZE-1:0] w_prod;
    logic signed [c_ACC_W-1:0]    w_acc_next;

    // Rescale the accumulator back to the Q format of the data words.
    function automatic logic [DATA_SIZE-1:0] f_result(input logic signed [c_ACC_W-1:0] acc);
`ifdef MODEL_STATE_SATURATION_EN
        logic signed [c_ACC_W-1:0] sh;
        sh = acc >>> FRACTION_SIZE;
        if (sh[c_ACC_W-1:DATA_SIZE-1] != {(c_ACC_W-DATA_SIZE+1){sh[c_ACC_W-1]}})
            return sh[c_ACC_W-1] ? {1'b1, {(DATA_SIZE-1){1'b0}}} : {1'b0, {(DATA_SIZE-1){1'b1}}};
        return sh[DATA_SIZE-1:0];
`else
        return DATA_SIZE'(acc >>> FRACTION_SIZE);
`endif
    endfunction

    assign w_st = (r_state == S_ST_ROW);
    assign w_jn = r_col[c_NI-1:0];
    assign w_ju = c_XI'(r_col - c_N);
    assign w_rn = r_row[c_NI-1:0];
    assign w_ry = r_row[c_YI-1:0];

    // Columns 0..N-1 walk the state vector, N..N+X-1 walk the input vector.
    always_comb begin
        w_coef = '0;
        w_vec  = '0;
        if (r_col < c_N) begin
            w_vec  = r_x[w_jn];
            w_coef = w_st ? r_a[w_rn][w_jn] : r_c[w_ry][w_jn];
        end else begin
            w_vec  = r_u[w_ju];
            w_coef = w_st ? r_b[w_rn][w_ju] : r_d[w_ry][w_ju];
        end
    end

    assign w_prod     = (2*DATA_SIZE)'(w_coef) * (2*DATA_SIZE)'(w_vec);
    assign w_acc_next = r_acc + c_ACC_W'(w_prod);

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_state  <= S_IDLE;
            r_row    <= '0;
            r_col    <= '0;
            r_k      <= '0;
            r_k_max  <= '0;
            r_acc    <= '0;
            r_y_en   <= 1'b0;
            r_y_idx  <= '0;
            r_y_step <= '0;
            r_y      <= '0;
            r_busy   <= 1'b0;
            r_ready  <= 1'b0;
            for (int i = 0; i < N; i++) begin
                r_x[i]  <= '0;
                r_xn[i] <= '0;
                for (int j = 0; j < N; j++) r_a[i][j] <= '0;
                for (int j = 0; j < X; j++) r_b[i][j] <= '0;
            end
            for (int i = 0; i < Y; i++) begin
                for (int j = 0; j < N; j++) r_c[i][j] <= '0;
                for (int j = 0; j < X; j++) r_d[i][j] <= '0;
            end
            for (int i = 0; i < X; i++) r_u[i] <= '0;
        end else begin
            r_y_en  <= 1'b0;
            r_ready <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (START) begin
                        r_k     <= '0;
                        r_k_max <= K_IN;
                        r_row   <= '0;
                        r_col   <= '0;
                        r_acc   <= '0;
                        r_busy  <= 1'b1;
                        if (K_IN == '0) begin
                            r_state <= S_DONE;
                            r_ready <= 1'b1;
                        end else begin
                            r_state <= S_OUT_ROW;
                        end
                    end
                    if (WR_ENABLE) begin
                        case (WR_SELECT)
                            3'd0: if ({1'b0, WR_ROW} < c_N && {1'b0, WR_COL} < c_N)
                                      r_a[WR_ROW[c_NI-1:0]][WR_COL[c_NI-1:0]] <= WR_DATA;
                            3'd1: if ({1'b0, WR_ROW} < c_N && {1'b0, WR_COL} < c_X)
                                      r_b[WR_ROW[c_NI-1:0]][WR_COL[c_XI-1:0]] <= WR_DATA;
                            3'd2: if ({1'b0, WR_ROW} < c_Y && {1'b0, WR_COL} < c_N)
                                      r_c[WR_ROW[c_YI-1:0]][WR_COL[c_NI-1:0]] <= WR_DATA;
                            3'd3: if ({1'b0, WR_ROW} < c_Y && {1'b0, WR_COL} < c_X)
                                      r_d[WR_ROW[c_YI-1:0]][WR_COL[c_XI-1:0]] <= WR_DATA;
                            3'd4: if ({1'b0, WR_ROW} < c_N) r_x[WR_ROW[c_NI-1:0]] <= WR_DATA;
                            3'd5: if ({1'b0, WR_ROW} < c_X) r_u[WR_ROW[c_XI-1:0]] <= WR_DATA;
                            default: ;
                        endcase
                    end
                end
                S_OUT_ROW: begin
                    r_acc <= w_acc_next;
                    if (r_col == c_NX_LAST) begin
                        r_col    <= '0;
                        r_state  <= S_OUT_EMIT;
                        r_y_en   <= 1'b1;
                        r_y_idx  <= r_row;
                        r_y_step <= r_k;
                        r_y      <= f_result(w_acc_next);
                    end else begin
                        r_col <= r_col + 1'b1;
                    end
                end
                S_OUT_EMIT: begin
                    r_acc <= '0;
                    if ({1'b0, r_row} == c_Y_LAST) begin
                        r_row   <= '0;
                        r_state <= S_ST_ROW;
                    end else begin
                        r_row   <= r_row + 1'b1;
                        r_state <= S_OUT_ROW;
                    end
                end
                S_ST_ROW: begin
                    r_acc <= w_acc_next;
                    if (r_col == c_NX_LAST) begin
                        r_col   <= '0;
                        r_state <= S_ST_EMIT;
                    end else begin
                        r_col <= r_col + 1'b1;
                    end
                end
                S_ST_EMIT: begin
                    r_xn[w_rn] <= f_result(r_acc);
                    r_acc      <= '0;
                    if ({1'b0, r_row} == c_N_LAST) begin
                        r_row   <= '0;
                        r_state <= S_COMMIT;
                    end else begin
                        r_row   <= r_row + 1'b1;
                        r_state <= S_ST_ROW;
                    end
                end
                S_COMMIT: begin
                    r_x <= r_xn;
                    if (({1'b0, r_k} + 1'b1) < {1'b0, r_k_max}) begin
                        r_k     <= r_k + 1'b1;
                        r_state <= S_OUT_ROW;
                    end else begin
                        r_state <= S_DONE;
                        r_ready <= 1'b1;
                    end
                end
                S_DONE: begin
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign Y_OUT_ENABLE = r_y_en;
    assign Y_OUT_INDEX  = r_y_idx;
    assign Y_OUT_STEP   = r_y_step;
    assign Y_OUT        = r_y;
    assign BUSY         = r_busy;
    assign READY        = r_ready;

endmodule

`default_nettype wire

// File: tb/tb_model_state_top_sequencer.sv
// ============================================================================
// Module   : tb_model_state_top_sequencer
// Summary  : Directed self-checking bench for model_state_top_sequencer.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_model_state_top_sequencer;

    localparam int DW = 64;
    localparam int IW = 8;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic [IW-1:0] k_in = '0;
    logic          wr_enable = 1'b0;
    logic [2:0]    wr_select = '0;
    logic [IW-1:0] wr_row = '0;
    logic [IW-1:0] wr_col = '0;
    logic [DW-1:0] wr_data = '0;
    logic          y_en;
    logic [IW-1:0] y_idx;
    logic [IW-1:0] y_step;
    logic [DW-1:0] y_out;
    logic          busy;
    logic          ready;

    always #5 clk = ~clk;

    model_state_top_sequencer dut (
        .CLK          (clk),
        .RST          (rst),
        .START        (start),
        .K_IN         (k_in),
        .WR_ENABLE    (wr_enable),
        .WR_SELECT    (wr_select),
        .WR_ROW       (wr_row),
        .WR_COL       (wr_col),
        .WR_DATA      (wr_data),
        .Y_OUT_ENABLE (y_en),
        .Y_OUT_INDEX  (y_idx),
        .Y_OUT_STEP   (y_step),
        .Y_OUT        (y_out),
        .BUSY         (busy),
        .READY        (ready)
    );

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [63:0] ys      [0:7][0:3];
    logic [63:0] log_y   [0:31];
    int          log_idx [0:31];
    int          log_step[0:31];
    int          y_count, ready_count, ready_edge, busy_count;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%h expected 0x%h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic load(input logic [2:0] sel, input int row, input int col, input logic [63:0] d);
        @(negedge clk);
        wr_enable = 1'b1;
        wr_select = sel;
        wr_row    = IW'(row);
        wr_col    = IW'(col);
        wr_data   = d;
        @(negedge clk);
        wr_enable = 1'b0;
    endtask

    task automatic load_ident(input logic [2:0] sel);
        for (int i = 0; i < 4; i++) load(sel, i, i, 64'h10000);
    endtask

    task automatic load_x0_ramp();
        for (int i = 0; i < 4; i++) load(3'd4, i, 0, 64'(i + 1) << 16);
    endtask

    // Start a run; edge index 0 is the edge that samples START.
    task automatic run(input int k, input bit inject);
        int n;
        for (int s = 0; s < 8; s++)
            for (int i = 0; i < 4; i++) ys[s][i] = 64'hBAD0_BAD0_BAD0_BAD0;
        y_count = 0; ready_count = 0; ready_edge = -1; busy_count = 0;
        @(negedge clk);
        k_in  = IW'(k);
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        n = 0;
        while (n < 2000) begin
            if (y_en) begin
                if (y_count < 32) begin
                    log_y[y_count]    = y_out;
                    log_idx[y_count]  = int'(y_idx);
                    log_step[y_count] = int'(y_step);
                end
                if (y_idx < 4 && y_step < 8) ys[y_step][y_idx[1:0]] = y_out;
                y_count++;
            end
            if (ready) begin
                ready_count++;
                if (ready_edge < 0) ready_edge = n;
            end
            if (busy) busy_count++;
            if (inject && n == 20) begin
                wr_enable = 1'b1; wr_select = 3'd0; wr_row = '0; wr_col = '0;
                wr_data = 64'h50000; start = 1'b1; k_in = 8'd5;
            end
            if (inject && n == 21) begin
                wr_enable = 1'b0; start = 1'b0;
            end
            if (ready_edge >= 0 && n >= ready_edge + 10) break;
            @(posedge clk);
            #1;
            n++;
        end
    endtask

    task automatic check_ident_log(input string tag);
        for (int i = 0; i < 8; i++) begin
            check($sformatf("%s_y%0d", tag, i), log_y[i], 64'((i % 4) + 1) << 16);
            check($sformatf("%s_idx%0d", tag, i), 64'(log_idx[i]), 64'(i % 4));
            check($sformatf("%s_step%0d", tag, i), 64'(log_step[i]), 64'(i / 4));
        end
    endtask

    initial begin
        do_reset();
        check("rst_y_en", 64'(y_en), 64'd0);
        check("rst_y_out", y_out, 64'd0);
        check("rst_y_idx", 64'(y_idx), 64'd0);
        check("rst_y_step", 64'(y_step), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_ready", 64'(ready), 64'd0);

        // Identity run, plus out-of-range writes that must not touch A[0][0]
        load_ident(3'd0);
        load_ident(3'd2);
        load_x0_ramp();
        load(3'd0, 4, 0, 64'h70000);
        load(3'd0, 0, 4, 64'h70000);
        load(3'd2, 0, 4, 64'h70000);
        run(2, 1'b0);
        check("id_count", 64'(y_count), 64'd8);
        check_ident_log("id");
        check("id_ready_edge", 64'(ready_edge), 64'd146);
        check("id_ready_count", 64'(ready_count), 64'd1);
        check("id_busy_cycles", 64'(busy_count), 64'd147);

        // Integrator: x(k+1) = x(k) + u
        do_reset();
        load_ident(3'd0);
        load_ident(3'd1);
        load_ident(3'd2);
        for (int i = 0; i < 4; i++) load(3'd5, i, 0, 64'h10000);
        run(3, 1'b0);
        for (int s = 0; s < 3; s++)
            for (int i = 0; i < 4; i++)
                check($sformatf("int_k%0d_y%0d", s, i), ys[s][i], 64'(s) << 16);
        check("int_ready_edge", 64'(ready_edge), 64'd219);
        run(1, 1'b0);
        for (int i = 0; i < 4; i++)
            check($sformatf("int_cont_y%0d", i), ys[0][i], 64'h30000);

        // Overflow on the state update
        do_reset();
        load(3'd0, 0, 0, 64'h20000);
        load_ident(3'd2);
        load(3'd4, 0, 0, 64'h4000_0000_0000_0000);
        run(2, 1'b0);
        check("ovf_k0_y0", ys[0][0], 64'h4000_0000_0000_0000);
        check("ovf_k1_y1", ys[1][1], 64'h0);
`ifdef MODEL_STATE_SATURATION_EN
        check("ovf_k1_y0", ys[1][0], 64'h7FFF_FFFF_FFFF_FFFF);
`else
        check("ovf_k1_y0", ys[1][0], 64'h8000_0000_0000_0000);
`endif

        // Zero steps
        do_reset();
        run(0, 1'b0);
        check("zero_ready_edge", 64'(ready_edge), 64'd0);
        check("zero_ready_count", 64'(ready_count), 64'd1);
        check("zero_busy_cycles", 64'(busy_count), 64'd1);
        check("zero_y_count", 64'(y_count), 64'd0);

        // Reset asserted in ST_ROW of step 0
        do_reset();
        load_ident(3'd0);
        load_ident(3'd2);
        load_x0_ramp();
        @(negedge clk);
        k_in  = 8'd3;
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (40) @(posedge clk);
        #1;
        check("abort_pre_busy", 64'(busy), 64'd1);
        check("abort_pre_y", y_out, 64'h40000);
        rst = 1'b1;
        #1;
        check("abort_y_out", y_out, 64'd0);
        check("abort_y_idx", 64'(y_idx), 64'd0);
        check("abort_y_en", 64'(y_en), 64'd0);
        check("abort_busy", 64'(busy), 64'd0);
        check("abort_ready", 64'(ready), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        ready_count = 0;
        for (int i = 0; i < 30; i++) begin
            @(posedge clk);
            #1;
            if (ready) ready_count++;
        end
        check("abort_no_ready", 64'(ready_count), 64'd0);
        run(1, 1'b0);
        check("abort_rerun_count", 64'(y_count), 64'd4);
        for (int i = 0; i < 4; i++)
            check($sformatf("abort_rerun_y%0d", i), ys[0][i], 64'd0);

        // Write and START while busy are ignored
        do_reset();
        load_ident(3'd0);
        load_ident(3'd2);
        load_x0_ramp();
        run(2, 1'b1);
        check("lock_count", 64'(y_count), 64'd8);
        check_ident_log("lock");
        check("lock_ready_count", 64'(ready_count), 64'd1);
        check("lock_ready_edge", 64'(ready_edge), 64'd146);
        run(1, 1'b0);
        check("lock_after_y0", ys[0][0], 64'h10000);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/model_state_top_sequencer.md
Name: model_state_top_sequencer

Overview:
- Runs a discrete state-space model for K steps on one shared signed fixed-point MAC:
  - y(k) = C·x(k) + D·u
  - x(k+1) = A·x(k) + B·u
- It is the parametrised, sequential successor to the fixed-size state-model constants. Sizes N/X/Y and the Q-format are generic, and the matrices, initial state and input are loaded at run time.
- Sits under the NTM model/state hierarchy and streams y(k) to downstream controller logic.

Parameters:
- DATA_SIZE, 64, signed word width.
- FRACTION_SIZE, 16, fractional bits (Q format; 1.0 = 0x10000).
- INDEX_SIZE, 8, index/step-counter width; N, X, Y ≤ 2^INDEX_SIZE.
- N, 4, state vector length.
- X, 4, input vector length.
- Y, 4, output vector length.

Ports:
- CLK  in  1  clock.
- RST  in  1  asynchronous, active-high reset.
- START  in  1  start pulse; sampled only in IDLE.
- K_IN  in  INDEX_SIZE  number of steps to run.
- WR_ENABLE  in  1  load strobe; honoured only in IDLE.
- WR_SELECT  in  3  target: 0=A(N×N), 1=B(N×X), 2=C(Y×N), 3=D(Y×X), 4=x0(row), 5=u(row), 6-7 ignored.
- WR_ROW  in  INDEX_SIZE  row index.
- WR_COL  in  INDEX_SIZE  column index; ignored for x0/u.
- WR_DATA  in  DATA_SIZE  signed value.
- Y_OUT_ENABLE  out  1  y element valid (one-cycle pulse).
- Y_OUT_INDEX  out  INDEX_SIZE  y element index.
- Y_OUT_STEP  out  INDEX_SIZE  step number k.
- Y_OUT  out  DATA_SIZE  y element value.
- BUSY  out  1  high in every state except IDLE.
- READY  out  1  one-cycle done pulse.

Behaviour:
- Reset:
  - All outputs reset to 0.
  - FSM goes to IDLE.
  - All storage (A, B, C, D, x, u, x_next, accumulator, counters) is cleared to 0.
  - Reset asserted mid-run aborts the run immediately; no READY is issued.
- Loads:
  - A WR_ENABLE in IDLE with in-range indices writes the target element on the next edge.
  - Out-of-range indices, WR_SELECT 6-7, or any write while BUSY are silently dropped.
- FSM states: IDLE, OUT_ROW, OUT_EMIT, ST_ROW, ST_EMIT, COMMIT, DONE.
  - IDLE
    - START with K_IN = 0 → DONE.
    - START with K_IN > 0 → OUT_ROW with row=0, k=0, accumulator cleared.
  - OUT_ROW: one MAC per cycle over j = 0..N+X-1.
    - j < N uses C[row][j]·x[j].
    - j ≥ N uses D[row][j-N]·u[j-N].
    - → OUT_EMIT after N+X cycles.
  - OUT_EMIT: drive Y_OUT_ENABLE=1 with Y_OUT_INDEX=row and Y_OUT_STEP=k; clear the accumulator.
    - row < Y-1 → next row, back to OUT_ROW.
    - Otherwise → ST_ROW with row=0.
  - ST_ROW: same MAC pattern using A[row][j] and B[row][j-N]; → ST_EMIT after N+X cycles.
  - ST_EMIT: write the result to x_next[row]; clear the accumulator.
    - row < N-1 → ST_ROW.
    - Otherwise → COMMIT.
  - COMMIT: x ← x_next, all elements at once.
    - k+1 < K_IN → OUT_ROW with k+1.
    - Otherwise → DONE.
  - DONE: READY=1 for exactly one cycle → IDLE.
- The x and u used during step k are the values captured at the start of that step; x_next never affects y(k).
- Timing:
  - Cycles per step: T = (Y+N)·(N+X+1) + 1.
  - With START sampled at edge 0, READY is high in cycle K·T + 1.
  - Defaults: T = 73.
- Arithmetic:
  - Each product is full precision (2·DATA_SIZE bits).
  - Accumulator width is 2·DATA_SIZE + INDEX_SIZE bits, signed.
  - Result = accumulator arithmetically shifted right by FRACTION_SIZE (floor), truncated to DATA_SIZE bits (two's-complement wrap).
- Y_OUT holds its last value between pulses.
- START and K_IN are ignored while BUSY.
- x keeps its final value after DONE. A subsequent run continues from it unless x0 is reloaded.

Optional Feature:
- Macro: MODEL_STATE_SATURATION_EN.
- Defined: the shifted result is clamped to [−2^(DATA_SIZE−1), 2^(DATA_SIZE−1)−1] before truncation. This applies to both Y_OUT and x_next.
- Undefined: plain wrap, as specified above.

Test Plan:
- Identity run:
  - Stimulus: A=C=I (diagonal 0x10000), B=D=0, x0=[0x10000, 0x20000, 0x30000, 0x40000], K_IN=2.
  - Required: Y_OUT sequence [0x10000, 0x20000, 0x30000, 0x40000] for step 0, repeated for step 1; Y_OUT_INDEX 0..3 and Y_OUT_STEP 0/1.
  - Required timing: 8 Y_OUT_ENABLE pulses; READY in cycle 147.
- Integrator:
  - Stimulus: A=B=C=I, D=0, x0=0, u=all 0x10000, K_IN=3.
  - Required: y elements are 0 at k=0, 0x10000 at k=1, 0x20000 at k=2; final x = 0x30000.
- Overflow:
  - Stimulus: A[0][0]=0x20000 (2.0), other elements 0, C=I, x0[0]=0x4000_0000_0000_0000, K_IN=2.
  - Required, macro undefined: y[0] at k=1 = 0x8000_0000_0000_0000.
  - Required, macro defined: y[0] at k=1 = 0x7FFF_FFFF_FFFF_FFFF.
- Zero steps:
  - Stimulus: K_IN=0 with START.
  - Required: READY high the cycle after START; BUSY high only in that cycle; no Y_OUT_ENABLE.
- Reset mid-run:
  - Stimulus: assert RST during ST_ROW of a K_IN=3 run.
  - Required: all outputs 0 immediately; no READY.
  - Follow-up: a new run with K_IN=1 and no reload outputs four y values of 0.
- Busy lockout:
  - Stimulus: WR_ENABLE to A[0][0]=0x50000 and a second START while BUSY.
  - Required: A is unchanged (results match the unmodified run); the READY count is 1.
